// File: rtl/tqvp_prism_evt.sv
// PRISM peripheral wrapper for the TinyQV bus: core control bits, extra-input register,
// edge-detecting interrupt sources and a timestamped event FIFO drained over the bus.
module tqvp_prism_evt #(
  parameter int NUM_SRC    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 16,
  parameter int EXTRA_W    = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_in,
  output logic               core_enable,
  output logic               core_reset,
  output logic [EXTRA_W-1:0] extra_out,
  input  logic [5:0]         address,
  input  logic [31:0]        data_in,
  input  logic [1:0]         data_write_n,
  input  logic [1:0]         data_read_n,
  output logic [31:0]        data_out,
  output logic               data_ready,
  output logic               user_interrupt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 5;

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_MASK   = 6'h04;
  localparam logic [5:0] A_PEND   = 6'h08;
  localparam logic [5:0] A_MODE   = 6'h0C;
  localparam logic [5:0] A_FIFO   = 6'h10;
  localparam logic [5:0] A_STATUS = 6'h14;
  localparam logic [5:0] A_EXTRA  = 6'h18;
  localparam logic [5:0] A_TS     = 6'h1C;

  logic                 r_core_enable, r_core_reset, r_fifo_en, r_irq, r_overflow;
  logic [NUM_SRC-1:0]   r_src_prev, r_pending, r_mask;
  logic [2*NUM_SRC-1:0] r_mode;
  logic [EXTRA_W-1:0]   r_extra;
  logic [TS_WIDTH-1:0]  r_ts;
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [31:0]          r_mem [FIFO_DEPTH];

  logic               w_wr, w_rd, w_wr_ctrl, w_wr_pend, w_wr_status, w_ts_clr;
  logic               w_full, w_empty, w_push, w_pop, w_push_ok, w_ovf_set, w_multi;
  logic [NUM_SRC-1:0] w_edge, w_pend_clr;
  logic [3:0]         w_idx;
  logic [31:0]        w_entry;
  logic               w_unused;

  assign w_wr        = (data_write_n == 2'b10);
  assign w_rd        = (data_read_n != 2'b11);
  assign w_wr_ctrl   = w_wr && (address == A_CTRL);
  assign w_wr_pend   = w_wr && (address == A_PEND);
  assign w_wr_status = w_wr && (address == A_STATUS);
  assign w_ts_clr    = w_wr_ctrl && data_in[1];
  assign w_unused    = &{1'b0, data_in};

  // NOTE: every variable gets a default before the loops so no latch can be inferred.
  always_comb begin
    w_edge = '0;
    w_idx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_edge[i] = (r_mode[2*i]   &  src_in[i] & ~r_src_prev[i]) |
                  (r_mode[2*i+1] & ~src_in[i] &  r_src_prev[i]);
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_edge[i]) w_idx = 4'(i);
    end
  end

  // More than one bit set means another source edged alongside the lowest one.
  assign w_multi    = |(w_edge & (w_edge - NUM_SRC'(1)));
  assign w_entry    = {1'b1, 1'b0, w_multi, 1'b0, w_idx, 24'(r_ts)};
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = r_fifo_en && (|w_edge);
  assign w_pop      = w_rd && (address == A_FIFO) && !w_empty;
  assign w_push_ok  = w_push && (!w_full || w_pop);
  assign w_ovf_set  = w_push && w_full && !w_pop;
  assign w_pend_clr = (w_wr_ctrl && data_in[31]) ? '1 :
                      (w_wr_pend ? data_in[NUM_SRC-1:0] : '0);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_enable <= 1'b0;
      r_core_reset  <= 1'b0;
      r_fifo_en     <= 1'b0;
      r_irq         <= 1'b0;
      r_overflow    <= 1'b0;
      r_src_prev    <= src_in;
      r_pending     <= '0;
      r_mask        <= '0;
      r_mode        <= '0;
      r_extra       <= '0;
      r_ts          <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_src_prev <= src_in;
      r_irq      <= |(r_pending & r_mask);
      r_pending  <= (r_pending & ~w_pend_clr) | w_edge;
      r_ts       <= w_ts_clr ? '0 : r_ts + TS_WIDTH'(1);
      if (w_wr_ctrl) begin
        r_core_reset  <= data_in[30];
        r_core_enable <= data_in[29];
        r_fifo_en     <= data_in[0];
      end
      if (w_wr && address == A_MASK)  r_mask  <= data_in[NUM_SRC-1:0];
      if (w_wr && address == A_MODE)  r_mode  <= data_in[2*NUM_SRC-1:0];
      if (w_wr && address == A_EXTRA) r_extra <= data_in[EXTRA_W-1:0];
      if (w_ovf_set)                          r_overflow <= 1'b1;
      else if (w_wr_status && data_in[10])    r_overflow <= 1'b0;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    end
  end

  // NOTE: storage is left unreset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wr_ptr] <= w_entry;
  end

  always_comb begin
    data_out = '0;
    case (address)
      A_CTRL:   data_out = {r_irq, r_core_reset, r_core_enable, 28'b0, r_fifo_en};
      A_MASK:   data_out = 32'(r_mask);
      A_PEND:   data_out = 32'(r_pending);
      A_MODE:   data_out = 32'(r_mode);
      A_FIFO:   data_out = w_empty ? 32'b0 : r_mem[r_rd_ptr];
      A_STATUS: data_out = {21'b0, r_overflow, w_empty, w_full, 3'b0, r_count};
      A_EXTRA:  data_out = 32'(r_extra);
      A_TS:     data_out = 32'(r_ts);
      default:  data_out = '0;
    endcase
  end

  assign core_enable    = r_core_enable;
  assign core_reset     = r_core_reset;
  assign extra_out      = r_extra;
  assign data_ready     = 1'b1;
  assign user_interrupt = r_irq;
endmodule

// File: doc/tqvp_prism_evt.md
# tqvp_prism_evt

Parametrised successor to the PRISM peripheral control wrapper for the TinyQV bus. It provides the core's enable/reset control bits and a software-driven extra-input register, now with configurable width. It adds NUM_SRC edge-detecting interrupt sources, each with its own mode, a mask and a pending register, and a timestamped event FIFO that software drains through the register interface. It sits between the TinyQV peripheral bus and a PRISM-class FSM core.

## Interface
- NUM_SRC, 8: number of event sources, 1..16.
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- TS_WIDTH, 16: timestamp counter width, 8..24.
- EXTRA_W, 9: extra_out width, 1..32.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- src_in  in  NUM_SRC  event inputs. They are already synchronised to clk.
- core_enable  out  1  FSM enable (CTRL[29]).
- core_reset  out  1  FSM debug reset (CTRL[30]).
- extra_out  out  EXTRA_W  software-written inputs to the core.
- address  in  6  register address.
- data_in  in  32  write data.
- data_write_n  in  2  11 = no write, 10 = 32-bit write. Other encodings are ignored.
- data_read_n  in  2  11 = no read. Any other value is a read.
- data_out  out  32  read data; combinational from address.
- data_ready  out  1  constant 1.
- user_interrupt  out  1  registered, equals |(pending & mask).

## Operation
Registers are 32 bits and word-aligned. Unused bits read 0.
- 0x00 CTRL:
  - [31] read = user_interrupt; write 1 clears all pending bits.
  - [30] core_reset.
  - [29] core_enable.
  - [1] write 1 zeroes the timestamp counter; self-clearing, reads 0.
  - [0] fifo_en.
- 0x04 MASK [NUM_SRC-1:0].
- 0x08 PENDING: read returns pending; write 1 to a bit clears that bit.
- 0x0C MODE: 2 bits per source at [2i+1:2i]. 00 off, 01 rising, 10 falling, 11 both edges.
- 0x10 FIFO: a read pops one entry. Entry layout:
  - [31] valid.
  - [29] multi: other sources also edged in the same cycle.
  - [27:24] source index.
  - [TS_WIDTH-1:0] timestamp.
  - An empty FIFO reads all 0 and does not pop.
- 0x14 STATUS:
  - [4:0] entry count.
  - [8] full.
  - [9] empty.
  - [10] overflow, sticky. Write 1 to [10] clears it.
- 0x18 EXTRA [EXTRA_W-1:0]: R/W, drives extra_out.
- 0x1C TS: current timestamp counter value, read-only.

Edge detection:
- src_prev holds src_in from the previous cycle.
- A qualifying edge (per MODE) on source i sets pending[i] at the same edge where the new src_in level is sampled.
- MODE=00 never sets pending. src_prev still tracks src_in.

Event capture:
- Capture happens only when fifo_en=1 and at least one source has a qualifying edge that cycle.
- Exactly one entry is pushed per cycle, for the lowest-index edged source.
- multi is set if any other source edged in the same cycle.
- Capture is independent of MASK.

Timestamp counter:
- Free-running and increments every cycle.
- Wraps from 2^TS_WIDTH−1 to 0.
- An entry records the counter value before that cycle's increment.

## Timing
- Reset (rst=1 at a clk edge):
  - All registers go to 0, including core_enable, core_reset, extra_out and user_interrupt.
  - The FIFO is emptied and overflow is cleared.
  - The timestamp counter is 0.
  - src_prev loads src_in, so no spurious edges occur after reset.
  - Reset during a pending FIFO read or write discards that read or write.
- Writes take effect at the clk edge where data_write_n=10.
- Reads are combinational with data_ready=1. A FIFO pop takes effect at the edge of every cycle in which data_read_n≠11 at 0x10.
- Interrupt latency: pending updates at edge k; user_interrupt updates at edge k+1.
- Edge arriving and W1C of the same bit in the same cycle: set wins.
- MASK changes do not alter pending.
- Push when full with no pop: the entry is dropped and overflow is set.
- Push and pop in the same cycle:
  - When full, both occur and count is unchanged.
  - When empty, the pop returns valid=0 and the push lands, so count becomes 1.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- CTRL[1] and a counter wrap in the same cycle: the clear wins, so the counter is 0.

## Test plan
- Reset with src_in=8'hFF, then MODE=16'h5555 (all rising): PENDING stays 0 and user_interrupt stays 0. Set MASK=1, raise src[0] with it low beforehand: PENDING=1 one cycle later, then user_interrupt=1 on the following cycle. W1C 0x08=1: interrupt drops.
- MODE src2 = both edges, fifo_en=1: toggle src[2] at TS=5 and TS=9. FIFO reads 0x8200_0005, then 0x8200_0009, then 0x0000_0000.
- Edges on src1 and src3 in the same cycle at TS=0x10: one entry 0xA100_0010. PENDING=0x0A.
- FIFO_DEPTH=4: generate 5 events without reading. STATUS reads count=4, full=1, overflow=1. A pop plus a push in the same cycle keeps count=4 and leaves overflow set until W1C.
- CTRL write 0x6000_0000: core_reset=1 and core_enable=1. Write EXTRA=0x1FF: extra_out=9'h1FF. Assert rst mid-stream: all outputs 0 and the FIFO is empty.
- TS_WIDTH=8: counter wraps 0xFF to 0x00. CTRL[1] written in the same cycle as the wrap gives 0.
